load_store_unit: RTL and testbench

Memory-side companion to the multicycle control unit. Drives the unified instruction/data memory, holds the instruction register, old-PC register and data register, and formats byte/halfword/word accesses by funct3 with byte masks and sign extension. It sits between the control unit/datapath and a synchronous-read, byte-masked 32-bit memory. It also detects misaligned or unsupported accesses and records them in sticky fault state.

---
 rtl/rv_mem_pkg.sv | 29 ++
 rtl/load_store_unit_if.sv | 14 +
 rtl/load_formatter.sv | 27 ++
 rtl/load_store_unit.sv | 115 +++++++++++
 tb/tb_load_store_unit.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/rv_mem_pkg.sv
// Shared constants and access-legality helper for the load/store unit.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [3:0] byte_mask_t;

    // True when funct3/offset describe a misaligned or unsupported access.
    function automatic logic access_bad(input logic [2:0] f3, input logic [1:0] off,
                                        input logic is_store);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = (off != 2'b00);
            F3_BU:   bad = is_store;
            F3_HU:   bad = is_store || off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-side bus between the load/store unit and the byte-masked memory.
interface load_store_unit_if
    import rv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    byte_mask_t        mem_wmask;
    logic [31:0]       mem_rdata;

    modport master (output mem_addr, output mem_wdata, output mem_wmask, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_wmask, output mem_rdata);
endinterface

// File: rtl/load_formatter.sv
// Extracts and extends the addressed lane of a returned memory word.
module load_formatter
    import rv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        bad
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = 8'(rdata >> {off, 3'b000});
        lane_h = off[1] ? rdata[31:16] : rdata[15:0];
        bad    = access_bad(funct3, off, 1'b0);
        case (funct3)
            F3_B:    data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   data = {24'b0, lane_b};
            F3_H:    data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   data = {16'b0, lane_h};
            F3_W:    data = rdata;
            default: data = '0;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Memory-side companion to the multicycle control: address mux, IR/old-PC/data
// registers, store lane steering, load formatting and sticky fault capture.
module load_store_unit
    import rv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter logic [31:0] RESET_INSTR = NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              adr_src,
    input  logic              ir_write,
    input  logic              mem_write,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] old_pc,
    output logic [31:0]       data,
    load_store_unit_if.master mem,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr
);
    logic [ADDR_W-1:0] sel;
    logic [1:0]        off, off_q;
    logic [2:0]        funct3, f3_q;
    logic              do_fetch, do_load, do_store;
    logic              fetch_bad, load_bad, store_bad, any_fault;
    logic              fetch_pend, load_pend;
    logic [31:0]       ir_q, data_q, fmt_data, load_data;
    logic              fmt_bad;
    byte_mask_t        wmask;
    logic [31:0]       wdat;

    load_formatter u_fmt (
        .rdata  (mem.mem_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (fmt_data),
        .bad    (fmt_bad)
    );

    always_comb begin
        sel      = adr_src ? addr : pc;
        off      = sel[1:0];
        funct3   = instr[14:12];
        // Data access takes priority over a simultaneous fetch strobe.
        do_fetch = ir_write && !adr_src;
        do_load  = adr_src && !mem_write;
        do_store = adr_src && mem_write;

        fetch_bad = do_fetch && (pc[1:0] != 2'b00);
        load_bad  = do_load  && access_bad(funct3, off, 1'b0);
        store_bad = do_store && access_bad(funct3, off, 1'b1);
        any_fault = fetch_bad || load_bad || store_bad;

        wmask = '0;
        wdat  = '0;
        if (do_store) begin
            case (funct3)
                F3_B: begin
                    wmask = byte_mask_t'(4'b0001 << off);
                    wdat  = {4{wdata[7:0]}};
                end
                F3_H: begin
                    wmask = byte_mask_t'(4'b0011 << off);
                    wdat  = {2{wdata[15:0]}};
                end
                F3_W: begin
                    wmask = 4'b1111;
                    wdat  = wdata;
                end
                default: ;
            endcase
        end
        if (store_bad || rst) wmask = '0;

        mem.mem_addr  = {sel[ADDR_W-1:2], 2'b00};
        mem.mem_wmask = wmask;
        mem.mem_wdata = wdat;

        // Return-cycle bypass so the new word is usable without a bubble.
        load_data = fmt_bad ? '0 : fmt_data;
        instr     = fetch_pend ? mem.mem_rdata : ir_q;
        data      = load_pend ? load_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q       <= RESET_INSTR;
            old_pc     <= '0;
            data_q     <= '0;
            fetch_pend <= 1'b0;
            load_pend  <= 1'b0;
            off_q      <= '0;
            f3_q       <= '0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            fetch_pend <= do_fetch && !fetch_bad;
            load_pend  <= do_load;
            if (do_fetch) old_pc <= pc;
            if (do_load) begin
                off_q <= off;
                f3_q  <= funct3;
            end
            if (fetch_pend) ir_q   <= mem.mem_rdata;
            if (load_pend)  data_q <= load_data;
            if (any_fault && !fault) begin
                fault      <= 1'b1;
                fault_addr <= sel;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: fetch/load returns queued at issue, checked on return.
module tb_load_store_unit;
    import rv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, addr, wdata;
    logic        adr_src, ir_write, mem_write;
    logic [31:0] instr, old_pc, data, fault_addr;
    logic        fault;

    load_store_unit_if #(.ADDR_W(32)) mif ();

    load_store_unit #(.ADDR_W(32), .RESET_INSTR(32'h0000_0013)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .addr       (addr),
        .wdata      (wdata),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .instr      (instr),
        .old_pc     (old_pc),
        .data       (data),
        .mem        (mif),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_instr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ret_t;

    ret_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] idle_rdata = 32'hDEAD_BEEF;
    localparam logic [31:0] WORD = 32'h8091_A2B3;
    localparam logic [31:0] SD   = 32'h1122_3344;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic store);
        return {17'b0, f3, 5'd1, store ? 7'b0100011 : 7'b0000011};
    endfunction

    // One bus cycle: drive at posedge+1, check at negedge, return at next posedge+1.
    task automatic cycle(input logic as_i, input logic iw_i, input logic mw_i,
                         input logic [31:0] pc_i, input logic [31:0] a_i, input logic [31:0] wd_i,
                         input logic push, input ret_t e,
                         input logic [3:0] exp_mask, input logic chk_wd, input logic [31:0] exp_wd);
        logic        had;
        ret_t        r;
        logic [31:0] s;
        had           = (exp_q.size() != 0);
        mif.mem_rdata = had ? exp_q[0].rdata : idle_rdata;
        adr_src       = as_i;
        ir_write      = iw_i;
        mem_write     = mw_i;
        pc            = pc_i;
        addr          = a_i;
        wdata         = wd_i;
        if (push) exp_q.push_back(e);
        s = as_i ? a_i : pc_i;
        @(negedge clk);
        check_eq("mem_addr", mif.mem_addr, {s[31:2], 2'b00});
        check_eq("mem_wmask", 32'(mif.mem_wmask), 32'(exp_mask));
        if (chk_wd) check_eq("mem_wdata", mif.mem_wdata, exp_wd);
        if (had) begin
            r = exp_q.pop_front();
            if (r.is_instr) check_eq("instr_ret", instr, r.exp);
            else            check_eq("load_ret", data, r.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] p, input logic [31:0] w);
        ret_t e;
        e = '{is_instr: 1'b1, rdata: w, exp: w};
        cycle(1'b0, 1'b1, 1'b0, p, 32'h0, 32'h0, 1'b1, e, 4'b0000, 1'b1, 32'h0);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] rd, input logic [31:0] exp);
        ret_t e;
        e = '{is_instr: 1'b0, rdata: rd, exp: exp};
        cycle(1'b1, 1'b0, 1'b0, 32'h0, a, 32'h0, 1'b1, e, 4'b0000, 1'b1, 32'h0);
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] m, input logic chk,
                         input logic [31:0] ewd);
        cycle(1'b1, 1'b0, 1'b1, 32'h0, a, SD, 1'b0, '0, m, chk, ewd);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, '0, 4'b0000, 1'b1, 32'h0);
    endtask

    initial begin
        rst = 1'b1; adr_src = 1'b0; ir_write = 1'b0; mem_write = 1'b0;
        pc = '0; addr = '0; wdata = '0; mif.mem_rdata = '0;
        @(posedge clk);
        #1;
        // Store strobe while in reset must not write.
        cycle(1'b1, 1'b0, 1'b1, 32'h0, 32'h200, SD, 1'b0, '0, 4'b0000, 1'b0, 32'h0);
        rst = 1'b0;
        check_eq("rst_instr", instr, 32'h0000_0013);
        check_eq("rst_old_pc", old_pc, 32'h0);
        check_eq("rst_data", data, 32'h0);
        check_eq("rst_fault", 32'(fault), 32'h0);
        check_eq("rst_fault_addr", fault_addr, 32'h0);

        fetch(32'h10, 32'h0050_0093);
        idle();
        check_eq("instr_held", instr, 32'h0050_0093);
        check_eq("old_pc", old_pc, 32'h10);

        // mem_write without adr_src is ignored.
        cycle(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, SD, 1'b0, '0, 4'b0000, 1'b1, 32'h0);

        fetch(32'h14, mk_instr(F3_B, 1'b0));  load(32'h103, WORD, 32'hFFFF_FF80);
        fetch(32'h18, mk_instr(F3_BU, 1'b0)); load(32'h103, WORD, 32'h0000_0080);
        fetch(32'h1C, mk_instr(F3_H, 1'b0));  load(32'h102, WORD, 32'hFFFF_8091);
        fetch(32'h20, mk_instr(F3_HU, 1'b0)); load(32'h100, WORD, 32'h0000_A2B3);
        fetch(32'h24, mk_instr(F3_W, 1'b0));  load(32'h100, WORD, WORD);
        idle();
        check_eq("data_held", data, WORD);
        check_eq("fault_after_loads", 32'(fault), 32'h0);

        fetch(32'h28, mk_instr(F3_B, 1'b1)); store(32'h201, 4'b0010, 1'b1, 32'h4444_4444);
        fetch(32'h2C, mk_instr(F3_H, 1'b1)); store(32'h202, 4'b1100, 1'b1, 32'h3344_3344);
        fetch(32'h30, mk_instr(F3_W, 1'b1)); store(32'h200, 4'b1111, 1'b1, SD);
        check_eq("fault_after_stores", 32'(fault), 32'h0);

        fetch(32'h34, mk_instr(F3_W, 1'b1)); store(32'h302, 4'b0000, 1'b0, 32'h0);
        check_eq("fault_set", 32'(fault), 32'h1);
        check_eq("fault_addr", fault_addr, 32'h302);
        fetch(32'h38, mk_instr(F3_H, 1'b0)); load(32'h405, 32'h1234_5678, 32'h0);
        idle();
        check_eq("fault_addr_sticky", fault_addr, 32'h302);
        check_eq("fault_sticky", 32'(fault), 32'h1);

        // Reset lands in the load-return cycle; the return is discarded.
        fetch(32'h3C, mk_instr(F3_W, 1'b0));
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h100, 32'h0, 1'b0, '0, 4'b0000, 1'b1, 32'h0);
        rst = 1'b1;
        idle_rdata = WORD;
        idle();
        rst = 1'b0;
        idle_rdata = 32'hDEAD_BEEF;
        check_eq("rst2_data", data, 32'h0);
        check_eq("rst2_instr", instr, 32'h0000_0013);
        check_eq("rst2_fault", 32'(fault), 32'h0);
        check_eq("rst2_fault_addr", fault_addr, 32'h0);

        // ir_write alongside a data access: load proceeds, IR/old_pc untouched.
        fetch(32'h40, mk_instr(F3_W, 1'b0));
        begin
            ret_t e;
            e = '{is_instr: 1'b0, rdata: WORD, exp: WORD};
            cycle(1'b1, 1'b1, 1'b0, 32'h80, 32'h100, 32'h0, 1'b1, e, 4'b0000, 1'b1, 32'h0);
        end
        idle();
        check_eq("conflict_old_pc", old_pc, 32'h40);
        check_eq("conflict_instr", instr, mk_instr(F3_W, 1'b0));
        check_eq("conflict_fault", 32'(fault), 32'h0);

        // Misaligned fetch faults and does not load IR.
        cycle(1'b0, 1'b1, 1'b0, 32'h12, 32'h0, 32'h0, 1'b0, '0, 4'b0000, 1'b1, 32'h0);
        idle();
        check_eq("fetch_fault", 32'(fault), 32'h1);
        check_eq("fetch_fault_addr", fault_addr, 32'h12);
        check_eq("fetch_fault_instr", instr, mk_instr(F3_W, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
